// File: rtl/control_sequencer_v2_if.sv
// Sequencer <-> datapath bundle: opcode/flags in, T-state and strobes out.
// Active-low strobes: ROM_OE, IR_OE, ACC_OE, AR_OE, ALU_en, HLT.
interface control_sequencer_v2_if #(
  parameter int OPCODE_W = 4,
  parameter int T_MAX    = 6
);
  localparam int TW = $clog2(T_MAX);

  logic [OPCODE_W-1:0] op_code;
  logic                Z;
  logic                C;
  logic [TW-1:0]       t_state;
  logic                instr_done;
  logic inc, PC_LD, PC_OE, MAR_LD, IR_LD;
  logic ACC_LD, B_LD, OUT_LD, AR_LD, S0, S1;
  logic ROM_OE, IR_OE, ACC_OE, AR_OE, ALU_en, HLT;

  modport master (
    input  op_code, Z, C,
    output t_state, instr_done,
    output inc, PC_LD, PC_OE, MAR_LD, IR_LD,
    output ACC_LD, B_LD, OUT_LD, AR_LD, S0, S1,
    output ROM_OE, IR_OE, ACC_OE, AR_OE, ALU_en, HLT
  );

  modport slave (
    output op_code, Z, C,
    input  t_state, instr_done,
    input  inc, PC_LD, PC_OE, MAR_LD, IR_LD,
    input  ACC_LD, B_LD, OUT_LD, AR_LD, S0, S1,
    input  ROM_OE, IR_OE, ACC_OE, AR_OE, ALU_en, HLT
  );
endinterface

// File: rtl/control_sequencer_v2.sv
// T-state control sequencer with JZ/JC, sticky halt and instr_done.
// Define SEQ_EARLY_END_EN to end each instruction at its last used state.
module control_sequencer_v2 #(
  parameter int OPCODE_W = 4,
  parameter int T_MAX    = 6
) (
  input logic                 clk,
  input logic                 clr,
  control_sequencer_v2_if.master bus
);
  localparam int TW = $clog2(T_MAX);
  localparam logic [TW-1:0] T_LAST = TW'(T_MAX - 1);
  localparam logic [TW-1:0] T2 = TW'(2);
  localparam logic [TW-1:0] T3 = TW'(3);
  localparam logic [TW-1:0] T4 = TW'(4);

  logic [TW-1:0] t_q, t_d;
  logic          halt_q, halt_d;
  logic          last;

  logic is_lda, is_alu, is_jmp, is_call, is_ret;
  logic is_out, is_hlt, is_jz, is_jc, is_nop;
  logic [1:0] alu_sel;

  always_comb begin
    is_lda  = bus.op_code == OPCODE_W'(0);
    is_alu  = bus.op_code >= OPCODE_W'(1) &&
              bus.op_code <= OPCODE_W'(4);
    is_jmp  = bus.op_code == OPCODE_W'(5);
    is_call = bus.op_code == OPCODE_W'(6);
    is_ret  = bus.op_code == OPCODE_W'(7);
    is_out  = bus.op_code == OPCODE_W'(8);
    is_hlt  = bus.op_code == OPCODE_W'(9);
    is_jz   = bus.op_code == OPCODE_W'(10);
    is_jc   = bus.op_code == OPCODE_W'(11);
    is_nop  = bus.op_code >= OPCODE_W'(12);
    // ADD..OR (1..4) map onto S1:S0 = 00..11
    alu_sel = bus.op_code[1:0] - 2'd1;
  end

`ifdef SEQ_EARLY_END_EN
  always_comb begin
    last = t_q == T_LAST;
    unique case (1'b1)
      is_lda | is_call:  last = t_q == T3;
      is_alu:            last = t_q == T4;
      is_jmp | is_ret | is_out |
      is_jz | is_jc | is_nop: last = t_q == T2;
      default: ;
    endcase
  end
`else
  always_comb last = t_q == T_LAST;
`endif

  always_comb begin
    t_d    = t_q;
    halt_d = halt_q;
    if (halt_q) begin
      t_d = t_q;
    end else if (t_q == T2 && is_hlt) begin
      halt_d = 1'b1;
    end else if (last) begin
      t_d = '0;
    end else begin
      t_d = t_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      t_q    <= '0;
      halt_q <= 1'b0;
    end else begin
      t_q    <= t_d;
      halt_q <= halt_d;
    end
  end

  always_comb begin
    bus.t_state    = clr ? '0 : t_q;
    bus.instr_done = !clr && !halt_q && last;
    bus.inc    = 1'b0;
    bus.PC_LD  = 1'b0;
    bus.PC_OE  = 1'b0;
    bus.MAR_LD = 1'b0;
    bus.IR_LD  = 1'b0;
    bus.ACC_LD = 1'b0;
    bus.B_LD   = 1'b0;
    bus.OUT_LD = 1'b0;
    bus.AR_LD  = 1'b0;
    bus.S0     = 1'b0;
    bus.S1     = 1'b0;
    bus.ROM_OE = 1'b1;
    bus.IR_OE  = 1'b1;
    bus.ACC_OE = 1'b1;
    bus.AR_OE  = 1'b1;
    bus.ALU_en = 1'b1;
    bus.HLT    = 1'b1;
    if (clr) begin
      bus.HLT = 1'b1;
    end else if (halt_q) begin
      bus.HLT = 1'b0;
    end else begin
      case (t_q)
        TW'(0): begin
          bus.PC_OE  = 1'b1;
          bus.MAR_LD = 1'b1;
        end
        TW'(1): begin
          bus.ROM_OE = 1'b0;
          bus.IR_LD  = 1'b1;
          bus.inc    = 1'b1;
        end
        T2: begin
          unique case (1'b1)
            is_lda | is_alu: begin
              bus.IR_OE  = 1'b0;
              bus.MAR_LD = 1'b1;
            end
            is_jmp: begin
              bus.IR_OE = 1'b0;
              bus.PC_LD = 1'b1;
            end
            is_call: begin
              bus.PC_OE = 1'b1;
              bus.AR_LD = 1'b1;
            end
            is_ret: begin
              bus.AR_OE = 1'b0;
              bus.PC_LD = 1'b1;
            end
            is_out: begin
              bus.ACC_OE = 1'b0;
              bus.OUT_LD = 1'b1;
            end
            is_hlt: bus.HLT = 1'b0;
            (is_jz & bus.Z) | (is_jc & bus.C): begin
              bus.IR_OE = 1'b0;
              bus.PC_LD = 1'b1;
            end
            default: ;
          endcase
        end
        T3: begin
          unique case (1'b1)
            is_lda: begin
              bus.ROM_OE = 1'b0;
              bus.ACC_LD = 1'b1;
            end
            is_alu: begin
              bus.ROM_OE = 1'b0;
              bus.B_LD   = 1'b1;
            end
            is_call: begin
              bus.IR_OE = 1'b0;
              bus.PC_LD = 1'b1;
            end
            default: ;
          endcase
        end
        T4: begin
          if (is_alu) begin
            bus.ALU_en = 1'b0;
            bus.ACC_LD = 1'b1;
            bus.S0     = alu_sel[0];
            bus.S1     = alu_sel[1];
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_control_sequencer_v2.sv
// Directed bench for control_sequencer_v2 (OPCODE_W=4, T_MAX=6).
// Expected strobe vectors are hand-written per instruction and state.
module tb_control_sequencer_v2;
  localparam int OW = 4;
  localparam int TM = 6;

  // active-view bit positions (low-active strobes inverted)
  localparam logic [16:0] INC   = 17'h1 << 16;
  localparam logic [16:0] PCLD  = 17'h1 << 15;
  localparam logic [16:0] PCOE  = 17'h1 << 14;
  localparam logic [16:0] MARLD = 17'h1 << 13;
  localparam logic [16:0] IRLD  = 17'h1 << 12;
  localparam logic [16:0] ACCLD = 17'h1 << 11;
  localparam logic [16:0] BLD   = 17'h1 << 10;
  localparam logic [16:0] OUTLD = 17'h1 << 9;
  localparam logic [16:0] ARLD  = 17'h1 << 8;
  localparam logic [16:0] SS0   = 17'h1 << 7;
  localparam logic [16:0] SS1   = 17'h1 << 6;
  localparam logic [16:0] ROM   = 17'h1 << 5;
  localparam logic [16:0] IROE  = 17'h1 << 4;
  localparam logic [16:0] ACCOE = 17'h1 << 3;
  localparam logic [16:0] AROE  = 17'h1 << 2;
  localparam logic [16:0] ALU   = 17'h1 << 1;
  localparam logic [16:0] HLTB  = 17'h1;
  localparam logic [16:0] F0 = PCOE | MARLD;
  localparam logic [16:0] F1 = ROM | IRLD | INC;

  logic clk = 1'b0;
  logic clr = 1'b1;
  int   checks = 0;
  int   failures = 0;
  logic [16:0] act;

  control_sequencer_v2_if #(.OPCODE_W(OW), .T_MAX(TM)) bus ();

  control_sequencer_v2 #(.OPCODE_W(OW), .T_MAX(TM)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always_comb act = {bus.inc, bus.PC_LD, bus.PC_OE,
                     bus.MAR_LD, bus.IR_LD, bus.ACC_LD,
                     bus.B_LD, bus.OUT_LD, bus.AR_LD,
                     bus.S0, bus.S1, ~bus.ROM_OE,
                     ~bus.IR_OE, ~bus.ACC_OE, ~bus.AR_OE,
                     ~bus.ALU_en, ~bus.HLT};

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cycle(input string tag, input int t,
                           input logic [16:0] ev,
                           input logic dn);
    #1;
    check($sformatf("%s_t%0d_strb", tag, t), 32'(act), 32'(ev));
    check($sformatf("%s_t%0d_ts", tag, t),
          32'(bus.t_state), 32'(t));
    check($sformatf("%s_t%0d_done", tag, t),
          32'(bus.instr_done), 32'(dn));
  endtask

  // n = number of listed execute states (T2..)
  task automatic run_op(input string tag, input logic [3:0] op,
                        input logic z, input logic c, input int n,
                        input logic [16:0] e2, input logic [16:0] e3,
                        input logic [16:0] e4);
    int len;
    logic [16:0] ev;
`ifdef SEQ_EARLY_END_EN
    len = n + 2;
`else
    len = TM;
`endif
    for (int t = 0; t < len; t++) begin
      step();
      clr = 1'b0;
      bus.op_code = op;
      // flags only matter in T2; drive opposite values elsewhere
      bus.Z = (t == 2) ? z : ~z;
      bus.C = (t == 2) ? c : ~c;
      if (t == 0) ev = F0;
      else if (t == 1) ev = F1;
      else if (t - 2 >= n) ev = '0;
      else if (t == 2) ev = e2;
      else if (t == 3) ev = e3;
      else ev = e4;
      chk_cycle(tag, t, ev, t == len - 1);
    end
  endtask

  initial begin
    bus.op_code = 4'd9;
    bus.Z = 1'b0;
    bus.C = 1'b0;
    clr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_cycle("reset", 0, '0, 1'b0);
    end

    run_op("lda", 4'd0, 0, 0, 2, IROE | MARLD, ROM | ACCLD, '0);
    run_op("add", 4'd1, 0, 0, 3, IROE | MARLD, ROM | BLD,
           ALU | ACCLD);
    run_op("sub", 4'd2, 0, 0, 3, IROE | MARLD, ROM | BLD,
           ALU | ACCLD | SS0);
    run_op("and", 4'd3, 0, 0, 3, IROE | MARLD, ROM | BLD,
           ALU | ACCLD | SS1);
    run_op("or", 4'd4, 0, 0, 3, IROE | MARLD, ROM | BLD,
           ALU | ACCLD | SS1 | SS0);
    run_op("jmp", 4'd5, 0, 0, 1, IROE | PCLD, '0, '0);
    run_op("call", 4'd6, 0, 0, 2, PCOE | ARLD, IROE | PCLD, '0);
    run_op("ret", 4'd7, 0, 0, 1, AROE | PCLD, '0, '0);
    run_op("out", 4'd8, 0, 0, 1, ACCOE | OUTLD, '0, '0);
    run_op("jz1", 4'd10, 1, 0, 1, IROE | PCLD, '0, '0);
    run_op("jz0", 4'd10, 0, 1, 1, '0, '0, '0);
    run_op("jc1", 4'd11, 0, 1, 1, IROE | PCLD, '0, '0);
    run_op("jc0", 4'd11, 1, 0, 1, '0, '0, '0);
    run_op("nop12", 4'd12, 0, 0, 1, '0, '0, '0);
    run_op("nop15", 4'd15, 1, 1, 1, '0, '0, '0);

    // clr mid-instruction (ALU op at T3)
    for (int t = 0; t < 3; t++) begin
      step();
      clr = 1'b0;
      bus.op_code = 4'd1;
    end
    step();
    clr = 1'b1;
    chk_cycle("midclr", 0, '0, 1'b0);
    run_op("jmp2", 4'd5, 0, 0, 1, IROE | PCLD, '0, '0);

    // HLT: freeze at T2, only clr exits
    step(); clr = 1'b0; bus.op_code = 4'd9;
    chk_cycle("hlt", 0, F0, 1'b0);
    step();
    chk_cycle("hlt", 1, F1, 1'b0);
    step();
    chk_cycle("hlt", 2, HLTB, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step();
      bus.op_code = 4'(i);
      bus.Z = i[0];
      chk_cycle($sformatf("halted%0d", i), 2, HLTB, 1'b0);
    end
    step();
    clr = 1'b1;
    chk_cycle("hltclr", 0, '0, 1'b0);
    run_op("post_hlt", 4'd7, 0, 0, 1, AROE | PCLD, '0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/control_sequencer_v2.md
# control_sequencer_v2

Parametrised successor to the fixed-length SAP-style control sequencer. It decodes an opcode of configurable width and drives a configurable number of T-states, with optional early instruction termination. It adds flag-conditional jumps (JZ, JC), a sticky halt latch and an instruction-complete strobe. It sits between the instruction register and the datapath: it receives the opcode from the IR and drives every bus load and output-enable strobe.

## Interface
- OPCODE_W, 4: opcode width; must be ≥4; opcodes ≥12 decode as NOP.
- T_MAX, 6: T-states per instruction when early termination is compiled out; must be ≥5.
- clk  in  1  rising-edge clock.
- clr  in  1  synchronous, active-high reset.
- op_code  in  OPCODE_W  opcode from the IR; valid from T2 onward.
- Z, C  in  1 each  ALU zero and carry flags; sampled combinationally in T2.
- t_state  out  $clog2(T_MAX)  current T-state index (debug).
- instr_done  out  1  high during the final T-state of each instruction.
- Active-high strobes: inc, PC_LD, PC_OE, MAR_LD, IR_LD, ACC_LD, B_LD, OUT_LD, AR_LD, S0, S1.
- Active-low strobes: ROM_OE, IR_OE, ACC_OE, AR_OE, ALU_en, HLT.

## Operation
- Opcodes: 0 LDA, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 JMP, 6 CALL, 7 RET, 8 OUT, 9 HLT, 10 JZ, 11 JC, all others NOP.
- Fetch cycles, common to all opcodes:
  - T0: PC_OE, MAR_LD.
  - T1: ROM_OE low, IR_LD, inc.
- LDA:
  - T2: IR_OE low, MAR_LD.
  - T3: ROM_OE low, ACC_LD; last state.
- ALU ops (opcodes 1-4):
  - T2: IR_OE low, MAR_LD.
  - T3: ROM_OE low, B_LD.
  - T4: ALU_en low, ACC_LD, S1:S0 = 00/01/10/11 for ADD/SUB/AND/OR; last state.
- JMP, T2: IR_OE low, PC_LD; last state.
- CALL:
  - T2: PC_OE, AR_LD.
  - T3: IR_OE low, PC_LD; last state.
- RET, T2: AR_OE low, PC_LD; last state.
- OUT, T2: ACC_OE low, OUT_LD; last state.
- JZ / JC, T2: if the selected flag (Z or C) is 1, IR_OE low and PC_LD; otherwise no strobes. Last state either way.
- NOP, T2: no strobes; last state.
- HLT, T2: HLT low; the halt latch sets on the closing edge.
- Halted:
  - t_state frozen at T2, HLT held low.
  - All other strobes inactive (active-high = 0, active-low = 1), instr_done = 0.
  - Only clr exits the halted state.
- Strobes outside the listed cycles are inactive.
- Strobe decode is combinational from the state register and op_code; the state register and halt latch are the only flops.

## Timing
- The state register advances on each rising clk edge.
- clr high at an edge: next state T0, halt latch cleared. This applies at any point, including mid-instruction and while halted.
- While clr is high, all strobes are forced inactive, t_state = 0 and instr_done = 0.
- First fetch: T0 occurs in the first cycle after clr deasserts.
- Instruction lengths with early termination: 3 cycles (JMP/RET/OUT/JZ/JC/NOP), 4 cycles (LDA/CALL), 5 cycles (ALU ops).
- instr_done is asserted in the last state. The following edge returns the counter to T0.
- Flags are read only during T2. Flag changes in other states have no effect.
- Any opcode change after T1 is the IR's responsibility; the sequencer does not latch op_code.

## Configuration
- SEQ_EARLY_END_EN defined: each instruction ends at its last state as listed above; the counter then returns to T0.
- SEQ_EARLY_END_EN undefined:
  - Every instruction runs T0..T_MAX-1, and the counter wraps from T_MAX-1 to T0.
  - Execute states after the listed last state produce no strobes.
  - instr_done pulses only in T_MAX-1.
- HLT behaviour is identical in both builds.

## Test plan
- Reset: hold clr high for 3 cycles with op_code = 9 → all strobes inactive, t_state = 0. On release: T0 shows PC_OE = 1, MAR_LD = 1; T1 shows ROM_OE = 0, IR_LD = 1, inc = 1.
- SUB (op 2), early end enabled: B_LD in T3; in T4 ACC_LD = 1, ALU_en = 0, S0 = 1, S1 = 0 and instr_done = 1; next cycle t_state = 0. Total 5 cycles.
- JZ (op 10):
  - Z = 1 → PC_LD = 1 and IR_OE = 0 in T2.
  - Z = 0 → no strobes in T2.
  - Both cases return to T0 after 3 cycles. JC with C toggled behaves identically.
- CALL then RET:
  - CALL: AR_LD with PC_OE in T2; PC_LD with IR_OE = 0 in T3.
  - RET: AR_OE = 0 with PC_LD in T2.
- HLT: HLT = 0 in T2, then remains frozen for 10 cycles with other strobes inactive. Asserting clr in cycle 7 → T0 on the next cycle after release.
- Macro undefined, T_MAX = 6: JMP → strobes only in T2, t_state sequence 0,1,2,3,4,5,0; instr_done asserted only in T5.
